// File: rtl/io_pkg.sv
// Shared definitions for the 1-bit input-pad conditioning blocks.
// Holds the debounce FSM state type, the legal parameter ranges and the
// helper that sizes the qualification counter.
package io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } deb_state_t;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int DEBOUNCE_CYCLES_MIN = 1;

  // Width needed to hold counts 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io1in_debounce_if.sv
// Signal bundle between a raw input pad and its debounce block.
// Optional feature macro: IO1IN_EDGE_STATS_EN adds the edge_count signal
// (and the EDGE_CNT_W parameter that sizes it).
interface io1in_debounce_if
`ifdef IO1IN_EDGE_STATS_EN
  #(parameter int EDGE_CNT_W = 16)
`endif
  ;
  logic pad_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
`ifdef IO1IN_EDGE_STATS_EN
  logic [EDGE_CNT_W-1:0] edge_count;
`endif

  // Pad side: drives the raw bit, observes the conditioned result.
  modport master (
    output pad_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
`ifdef IO1IN_EDGE_STATS_EN
    , input edge_count
`endif
  );

  // Conditioning side: consumes the raw bit, produces level and strobes.
  modport slave (
    input  pad_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output busy
`ifdef IO1IN_EDGE_STATS_EN
    , output edge_count
`endif
  );

endinterface

// File: rtl/io_sync2.sv
// Parameterized flop-chain synchronizer for asynchronous pad bits.
// The chain is forced to RESET_LEVEL during reset so no stale pad value
// survives into the first post-reset cycles.
module io_sync2 #(
  parameter int STAGES      = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift the raw bit through the chain; bit 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= {STAGES{RESET_LEVEL}};
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

  // Two flops minimum, otherwise the chain does not synchronize.
  a_stages_legal: assert property (@(posedge clk) STAGES >= 2)
    else $error("io_sync2: STAGES=%0d is below 2", STAGES);

endmodule

// File: rtl/io1in_debounce.sv
// Input-pad conditioner: synchronizes one raw pad bit, debounces it with a
// consecutive-cycle filter and emits a clean level plus 1-cycle rise/fall
// strobes.
// Optional feature macro: IO1IN_EDGE_STATS_EN adds a wrapping count of
// accepted rising edges on bus.edge_count.
module io1in_debounce
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
`ifdef IO1IN_EDGE_STATS_EN
  , parameter int EDGE_CNT_W    = 16
`endif
) (
  input logic             clk,
  input logic             rst,
  io1in_debounce_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit PARAMS_OK = (SYNC_STAGES >= SYNC_STAGES_MIN) &&
                             (SYNC_STAGES <= SYNC_STAGES_MAX) &&
                             (DEBOUNCE_CYCLES >= DEBOUNCE_CYCLES_MIN);

  logic             sync_q;
  logic             differ;
  logic             accept;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level, level_n;
  logic             rise, rise_n;
  logic             fall, fall_n;

  io_sync2 #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pad_in),
    .q   (sync_q)
  );

  assign differ = (sync_q != level);

  // Next-state: qualify a disagreeing synchronized bit for DEBOUNCE_CYCLES
  // consecutive cycles before adopting it; any agreement cancels the attempt.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (differ) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // A one-cycle filter has nothing to qualify.
            accept = 1'b1;
          end else begin
            state_n = QUAL;
            cnt_n   = CNT_ONE;
          end
        end
      end
      QUAL: begin
        if (!differ) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          accept  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
    endcase
    if (accept) begin
      level_n = sync_q;
      rise_n  = sync_q;
      fall_n  = ~sync_q;
    end
  end

  // State, counter, level and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  assign bus.level_out  = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.busy       = (state == QUAL);

`ifdef IO1IN_EDGE_STATS_EN
  logic [EDGE_CNT_W-1:0] edge_cnt;

  // Count accepted rising edges one cycle after each rise strobe; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (rise) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign bus.edge_count = edge_cnt;
`endif

  a_params_legal: assert property (@(posedge clk) PARAMS_OK)
    else $error("io1in_debounce: illegal SYNC_STAGES=%0d or DEBOUNCE_CYCLES=%0d",
                SYNC_STAGES, DEBOUNCE_CYCLES);

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(rise && fall));

  a_cnt_bounded: assert property (@(posedge clk) cnt <= CNT_LAST);

endmodule
